pmem_responder: RTL and testbench

Line-granularity physical-memory responder on the far side of the cache system's pmem port. It accepts one 128-bit line read or write at a time from the L1 arbiter, or the L2 when present. After a fixed programmable latency it completes the request with a single-cycle `pmem_resp`. It is the synthesizable memory target for simulation and FPGA bring-up of the full CPU plus cache hierarchy.

---
 rtl/pmem_pkg.sv | 39 +++
 rtl/pmem_line_ram.sv | 52 +++++
 rtl/pmem_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_pmem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// ---------------------------------------------------------------------------
// pmem_pkg
// Shared types and constants for the pmem_responder line memory target.
//   PMEM_LINE_W   : width of one cache line (bits)
//   PMEM_ADDR_W   : width of the pmem byte address
//   PMEM_OFFSET_W : byte-offset bits inside a line (ignored by the responder)
//   PMEM_CNT_W    : width of the latency down-counter (LATENCY <= 255)
//   pmem_state_t  : control FSM states
//   pmem_line_t   : one 128-bit line
//   pmem_sat_inc  : saturating 16-bit increment used by the statistics counters
// ---------------------------------------------------------------------------
package pmem_pkg;

  localparam int PMEM_LINE_W   = 128;
  localparam int PMEM_ADDR_W   = 16;
  localparam int PMEM_OFFSET_W = 4;
  localparam int PMEM_CNT_W    = 8;

  typedef logic [PMEM_LINE_W-1:0] pmem_line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } pmem_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] pmem_sat_inc(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pmem_line_ram.sv
// ---------------------------------------------------------------------------
// pmem_line_ram
// LINES x 128-bit line store with one synchronous write port and one
// registered read port. Kept separate from the control logic so a vendor
// block RAM or a preloaded model can be dropped in unchanged.
// Ports:
//   clk, rst_n : clock, async active-low reset (read register only; the
//                array itself is never cleared)
//   we, widx, wdata : write enable / line index / line data
//   re, ridx   : read enable / line index; data lands in rdata at the edge
//   rdata      : registered read line, holds until the next enabled read
// ---------------------------------------------------------------------------
module pmem_line_ram
  import pmem_pkg::*;
#(
  parameter int LINES = 4096,
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  pmem_line_t       wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] ridx,
  output pmem_line_t       rdata
);

  pmem_line_t mem_r [LINES];
  pmem_line_t rdata_r;

  // Array write port: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[widx] <= wdata;
    end
  end

  // Registered read port; cleared by reset, otherwise holds the last read line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {PMEM_LINE_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[ridx];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/pmem_responder.sv
// ---------------------------------------------------------------------------
// pmem_responder
// Line-granularity physical memory target for the cache hierarchy pmem port.
// Captures one 128-bit line read or write, waits LATENCY edges and completes
// it with a single-cycle pmem_resp. One request per LATENCY+2 cycles.
//
// Parameters: LINES (power of two, 1..4096), LATENCY (1..255)
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   pmem_read, pmem_write : request strobes, held until pmem_resp
//   pmem_addr [15:0]      : byte address; line index = addr[15:4] mod LINES
//   pmem_wdata [127:0]    : write line
//   pmem_resp             : one-cycle completion pulse
//   pmem_rdata [127:0]    : last read line (registered)
//   protocol_err          : sticky; read+write together, or request abandoned
//   rd_count, wr_count    : completed-operation counters
// Build option: define PMEM_RESPONDER_STATS_EN to build the saturating
// rd_count / wr_count counters; otherwise both outputs are tied to zero.
//
// Timing note: the FSM sits in RESP during the cycle before the response is
// visible. pmem_resp and the write commit are both registered off RESP, so
// the pulse appears on the cycle after RESP (which is also the dead GAP
// cycle) and the requester's next capture can land at E(LATENCY+2).
// ---------------------------------------------------------------------------
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int LINES   = 4096,
  parameter int LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [PMEM_ADDR_W-1:0] pmem_addr,
  input  pmem_line_t             pmem_wdata,
  output logic                   pmem_resp,
  output pmem_line_t             pmem_rdata,
  output logic                   protocol_err,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [PMEM_CNT_W-1:0] LAT_LOAD = PMEM_CNT_W'(LATENCY - 1);

  pmem_state_t           state_r;
  pmem_state_t           next_state_s;
  logic [PMEM_CNT_W-1:0] cnt_r;
  logic                  op_write_r;
  logic [IDX_W-1:0]      idx_r;
  pmem_line_t            wdata_r;
  logic                  err_r;
  logic                  resp_r;

  logic                  req_s;
  logic                  capture_s;
  logic [IDX_W-1:0]      addr_idx_s;
  logic                  resp_next_s;
  logic                  err_set_s;
  logic                  ram_re_s;
  logic [IDX_W-1:0]      ram_ridx_s;
  logic                  ram_we_s;
  logic                  unused_addr_s;

  assign req_s     = pmem_read | pmem_write;
  assign capture_s = (state_r == IDLE) && req_s;

  // Low index bits only; higher lines alias silently, offset bits are dropped.
  generate
    if (LINES > 1) begin : g_idx
      assign addr_idx_s = pmem_addr[PMEM_OFFSET_W +: IDX_W];
    end else begin : g_idx_one
      assign addr_idx_s = 1'b0;
    end
  endgenerate
  assign unused_addr_s = ^pmem_addr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. BUSY leaves on the edge where the counter reaches 0.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          next_state_s = (LATENCY == 1) ? RESP : BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r <= 8'd1) begin
          next_state_s = RESP;
        end else begin
          next_state_s = BUSY;
        end
      end
      RESP:    next_state_s = GAP;
      GAP:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output / control decode for registered outputs and the line RAM.
  always_comb begin
    resp_next_s = 1'b0;
    err_set_s   = 1'b0;
    ram_re_s    = 1'b0;
    ram_ridx_s  = idx_r;
    ram_we_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // LATENCY=1 enters RESP straight from capture, so the read uses the
        // live request rather than the not-yet-captured fields.
        ram_ridx_s = addr_idx_s;
        if (req_s && pmem_read && pmem_write) begin
          err_set_s = 1'b1;
        end else begin
          err_set_s = 1'b0;
        end
        if (req_s && (next_state_s == RESP) && !pmem_write) begin
          ram_re_s = 1'b1;
        end else begin
          ram_re_s = 1'b0;
        end
      end
      BUSY: begin
        // Requester dropping both strobes mid-wait is an abandoned request.
        if (!req_s) begin
          err_set_s = 1'b1;
        end else begin
          err_set_s = 1'b0;
        end
        if ((next_state_s == RESP) && !op_write_r) begin
          ram_re_s = 1'b1;
        end else begin
          ram_re_s = 1'b0;
        end
      end
      RESP: begin
        resp_next_s = 1'b1;
        ram_we_s    = op_write_r;
      end
      GAP: begin
        resp_next_s = 1'b0;
      end
      default: begin
        resp_next_s = 1'b0;
      end
    endcase
  end

  // Request capture and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= 8'd0;
      op_write_r <= 1'b0;
      idx_r      <= {IDX_W{1'b0}};
      wdata_r    <= {PMEM_LINE_W{1'b0}};
    end else if (capture_s) begin
      cnt_r      <= LAT_LOAD;
      op_write_r <= pmem_write;
      idx_r      <= addr_idx_s;
      wdata_r    <= pmem_wdata;
    end else if ((state_r == BUSY) && (cnt_r != 8'd0)) begin
      cnt_r      <= cnt_r - 8'd1;
    end else begin
      cnt_r      <= cnt_r;
    end
  end

  // Response pulse and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      resp_r <= resp_next_s;
      err_r  <= err_r | err_set_s;
    end
  end

  pmem_line_ram #(
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we_s),
    .widx  (idx_r),
    .wdata (wdata_r),
    .re    (ram_re_s),
    .ridx  (ram_ridx_s),
    .rdata (pmem_rdata)
  );

  assign pmem_resp    = resp_r;
  assign protocol_err = err_r;

`ifdef PMEM_RESPONDER_STATS_EN
  logic [15:0] rd_cnt_r;
  logic [15:0] wr_cnt_r;

  // Completed-operation counters, bumped as the operation leaves RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_r <= 16'd0;
      wr_cnt_r <= 16'd0;
    end else if (state_r == RESP) begin
      if (op_write_r) begin
        wr_cnt_r <= pmem_sat_inc(wr_cnt_r);
      end else begin
        rd_cnt_r <= pmem_sat_inc(rd_cnt_r);
      end
    end else begin
      rd_cnt_r <= rd_cnt_r;
      wr_cnt_r <= wr_cnt_r;
    end
  end

  assign rd_count = rd_cnt_r;
  assign wr_count = wr_cnt_r;
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// ---------------------------------------------------------------------------
// tb_pmem_responder
// Directed bench for pmem_responder: one instance at LATENCY=4 and one at
// LATENCY=1, each with its own request inputs and a shared reset.
// ---------------------------------------------------------------------------
module tb_pmem_responder;

  logic         clk;
  logic         rst_n;

  logic         rd4, wr4, resp4, err4;
  logic [15:0]  addr4, rc4, wc4;
  logic [127:0] wd4, rdata4;

  logic         rd1, wr1, resp1, err1;
  logic [15:0]  addr1, rc1, wc1;
  logic [127:0] wd1, rdata1;

  int n_cmp;
  int n_bad;

  localparam logic [127:0] PRE = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] A5  = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
  localparam logic [127:0] XV  = 128'hDEADBEEF00000000CAFEF00D12345678;
  localparam logic [127:0] PV  = 128'h11111111222222223333333344444444;
  localparam logic [127:0] QV  = 128'h99999999888888887777777766666666;
  localparam logic [127:0] Y1  = 128'h0000000100000002000000030000000F;
  localparam logic [127:0] Y2  = 128'hF0F0F0F00F0F0F0FF0F0F0F00F0F0F0F;
  localparam logic [127:0] W1  = 128'h3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C;

`ifdef PMEM_RESPONDER_STATS_EN
  localparam logic [15:0] EXP_RC = 16'd3;
  localparam logic [15:0] EXP_WC = 16'd2;
`else
  localparam logic [15:0] EXP_RC = 16'd0;
  localparam logic [15:0] EXP_WC = 16'd0;
`endif

  pmem_responder #(.LINES(4096), .LATENCY(4)) dut (
    .clk (clk), .rst_n (rst_n),
    .pmem_read (rd4), .pmem_write (wr4), .pmem_addr (addr4), .pmem_wdata (wd4),
    .pmem_resp (resp4), .pmem_rdata (rdata4), .protocol_err (err4),
    .rd_count (rc4), .wr_count (wc4)
  );

  pmem_responder #(.LINES(4096), .LATENCY(1)) dut1 (
    .clk (clk), .rst_n (rst_n),
    .pmem_read (rd1), .pmem_write (wr1), .pmem_addr (addr1), .pmem_wdata (wd1),
    .pmem_resp (resp1), .pmem_rdata (rdata1), .protocol_err (err1),
    .rd_count (rc1), .wr_count (wc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [127:0] wd);
    if (sel == 1) begin
      rd1 = rd; wr1 = wr; addr1 = addr; wd1 = wd;
    end else begin
      rd4 = rd; wr4 = wr; addr4 = addr; wd4 = wd;
    end
  endtask

  function automatic logic get_resp(input int sel);
    return (sel == 1) ? resp1 : resp4;
  endfunction

  function automatic logic [127:0] get_rdata(input int sel);
    return (sel == 1) ? rdata1 : rdata4;
  endfunction

  // Request already driven; E0 is the next rising edge. Ends at the
  // falling edge after E(lat), where the pulse must be visible.
  task automatic wait_resp(input string tag, input int sel, input int lat,
                           input logic chk_rd, input logic [127:0] exp_rd);
    for (int k = 0; k <= lat; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("%s_resp_E%0d", tag, k), 128'(get_resp(sel)), 128'(k == lat));
    end
    if (chk_rd) begin
      check_eq({tag, "_rdata"}, get_rdata(sel), exp_rd);
    end
  endtask

  // One edge in which no response may be visible.
  task automatic gap_step(input string tag, input int sel);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_gap_resp"}, 128'(get_resp(sel)), 128'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(4, 1'b0, 1'b0, 16'h0000, 128'd0);
    drive(1, 1'b0, 1'b0, 16'h0000, 128'd0);
    repeat (3) @(negedge clk);

    check_eq("rst_resp",  128'(resp4),  128'd0);
    check_eq("rst_rdata", rdata4,       128'd0);
    check_eq("rst_err",   128'(err4),   128'd0);
    check_eq("rst_rc",    128'(rc4),    128'd0);
    check_eq("rst_wc",    128'(wc4),    128'd0);
    rst_n = 1'b1;

    // Preload line 0x012, then read it back: pulse exactly at E4, low at E5.
    drive(4, 1'b0, 1'b1, 16'h0120, PRE);
    wait_resp("pre_wr", 4, 4, 1'b0, 128'd0);
    drive(4, 1'b0, 1'b0, 16'h0000, 128'd0);
    gap_step("pre_wr", 4);
    check_eq("wr_keeps_rdata", rdata4, 128'd0);
    drive(4, 1'b1, 1'b0, 16'h0120, 128'd0);
    wait_resp("rd012", 4, 4, 1'b1, PRE);
    drive(4, 1'b0, 1'b0, 16'h0000, 128'd0);
    gap_step("rd012", 4);

    // Write 0x0FF7, read 0x0FF0 with the read already high during the gap.
    drive(4, 1'b0, 1'b1, 16'h0FF7, A5);
    wait_resp("wrff", 4, 4, 1'b0, 128'd0);
    drive(4, 1'b1, 1'b0, 16'h0FF0, 128'd0);
    gap_step("wrff", 4);
    wait_resp("rdff", 4, 4, 1'b1, A5);
    drive(4, 1'b0, 1'b0, 16'h0000, 128'd0);
    gap_step("rdff", 4);
    check_eq("err_clean", 128'(err4), 128'd0);

    // Read+write together: a write, and the error sticks.
    drive(4, 1'b1, 1'b1, 16'h0040, XV);
    wait_resp("rdwr", 4, 4, 1'b0, 128'd0);
    check_eq("err_set", 128'(err4), 128'd1);
    drive(4, 1'b0, 1'b0, 16'h0000, 128'd0);
    gap_step("rdwr", 4);
    drive(4, 1'b1, 1'b0, 16'h0040, 128'd0);
    wait_resp("rd040", 4, 4, 1'b1, XV);
    drive(4, 1'b0, 1'b0, 16'h0000, 128'd0);
    gap_step("rd040", 4);
    check_eq("err_sticky", 128'(err4), 128'd1);

    // Line 5 gets PV, then a write of QV is killed by reset before commit.
    drive(4, 1'b0, 1'b1, 16'h0050, PV);
    wait_resp("wr5", 4, 4, 1'b0, 128'd0);
    drive(4, 1'b0, 1'b0, 16'h0000, 128'd0);
    gap_step("wr5", 4);
    drive(4, 1'b0, 1'b1, 16'h0050, QV);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    drive(4, 1'b0, 1'b0, 16'h0000, 128'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("rstmid_resp%0d", k), 128'(resp4), 128'd0);
    end
    check_eq("rstmid_rdata", rdata4, 128'd0);
    check_eq("rstmid_err",   128'(err4), 128'd0);
    check_eq("rstmid_rc",    128'(rc4), 128'd0);
    check_eq("rstmid_wc",    128'(wc4), 128'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("rstrel_resp%0d", k), 128'(resp4), 128'd0);
    end

    // Three reads, two writes after reset.
    drive(4, 1'b1, 1'b0, 16'h0050, 128'd0);
    wait_resp("rd5", 4, 4, 1'b1, PV);
    drive(4, 1'b0, 1'b0, 16'h0000, 128'd0);
    gap_step("rd5", 4);
    drive(4, 1'b0, 1'b1, 16'h0070, Y1);
    wait_resp("wr7", 4, 4, 1'b0, 128'd0);
    drive(4, 1'b0, 1'b1, 16'h0080, Y2);
    gap_step("wr7", 4);
    wait_resp("wr8", 4, 4, 1'b0, 128'd0);
    drive(4, 1'b1, 1'b0, 16'h007C, 128'd0);
    gap_step("wr8", 4);
    wait_resp("rd7", 4, 4, 1'b1, Y1);
    drive(4, 1'b1, 1'b0, 16'h0080, 128'd0);
    gap_step("rd7", 4);
    wait_resp("rd8", 4, 4, 1'b1, Y2);
    drive(4, 1'b0, 1'b0, 16'h0000, 128'd0);
    gap_step("rd8", 4);
    check_eq("rd_count", 128'(rc4), 128'(EXP_RC));
    check_eq("wr_count", 128'(wc4), 128'(EXP_WC));
    check_eq("err_after_rst", 128'(err4), 128'd0);

    // Abandoned read: still completes, error set.
    drive(4, 1'b1, 1'b0, 16'h0120, 128'd0);
    @(posedge clk);
    @(negedge clk);
    drive(4, 1'b0, 1'b0, 16'h0000, 128'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("aband_resp_E%0d", k), 128'(resp4), 128'(k == 4));
    end
    check_eq("aband_rdata", rdata4, PRE);
    check_eq("aband_err", 128'(err4), 128'd1);
    gap_step("aband", 4);

    // LATENCY=1: resp at E1, next capture at E3, resp at E4.
    drive(1, 1'b0, 1'b1, 16'h0030, W1);
    wait_resp("l1_wr", 1, 1, 1'b0, 128'd0);
    drive(1, 1'b0, 1'b0, 16'h0000, 128'd0);
    gap_step("l1_wr", 1);
    drive(1, 1'b1, 1'b0, 16'h0030, 128'd0);
    wait_resp("l1_rda", 1, 1, 1'b1, W1);
    gap_step("l1_rda", 1);
    wait_resp("l1_rdb", 1, 1, 1'b1, W1);
    drive(1, 1'b0, 1'b0, 16'h0000, 128'd0);
    gap_step("l1_rdb", 1);
    check_eq("l1_err", 128'(err1), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
